// File: rtl/mp_line_bridge_if.sv
// Cache-line port (core side) and burst host port (memory-controller side) of mp_line_bridge.
// The bridge uses the master view; the surrounding system or bench uses the slave view.
interface mp_line_bridge_if;
    logic         mem_request;
    logic         mem_rwn;
    logic [15:0]  mem_addr;
    logic [127:0] mem_write_data;
    logic         mem_finish;
    logic [127:0] mem_read_data;
    logic         mem_partial;
    logic         mem_replace;
    logic [4:0]   mem_replace_set;
    logic [6:0]   mem_replace_tag;
    logic         host_req;
    logic         host_rwn;
    logic         host_burst;
    logic [31:0]  host_addr;
    logic         host_ack;
    logic [1:0]   host_txm;
    logic [15:0]  host_txd;
    logic         host_txd_ack;
    logic [15:0]  host_rxd;
    logic         host_rxd_vld;
    logic         err;

    modport master (
        input  mem_request, mem_rwn, mem_addr, mem_write_data,
        input  host_ack, host_txd_ack, host_rxd, host_rxd_vld,
        output mem_finish, mem_read_data, mem_partial, mem_replace,
        output mem_replace_set, mem_replace_tag,
        output host_req, host_rwn, host_burst, host_addr, host_txm, host_txd,
        output err
    );

    modport slave (
        output mem_request, mem_rwn, mem_addr, mem_write_data,
        output host_ack, host_txd_ack, host_rxd, host_rxd_vld,
        input  mem_finish, mem_read_data, mem_partial, mem_replace,
        input  mem_replace_set, mem_replace_tag,
        input  host_req, host_rwn, host_burst, host_addr, host_txm, host_txd,
        input  err
    );
endinterface

// File: rtl/mp_line_bridge.sv
// Turns each 128-bit cache-line read/write from the core into one 8-beat x 16-bit
// burst on the memory-controller host port, then pulses mem_finish.
//
// state | meaning
// IDLE  | waiting for mem_request; latches address, direction and write line
// CMD   | host_req asserted until host_ack; beats may already flow
// DATA  | command accepted, collecting remaining beats
// DONE  | one-cycle mem_finish with read line and replace info
module mp_line_bridge #(
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int          BEATS = 8
) (
    input  logic          clk,
    input  logic          rst,
    mp_line_bridge_if.master bus
);
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t       state, state_nx;
    logic [2:0]   beat, beat_nx;
    logic         ack_seen, ack_seen_nx;
    logic         full, full_nx;
    logic         err_q, err_set;
    logic [11:0]  line_q;
    logic         rwn_q;
    logic [127:0] wbuf, rbuf;
    logic         busy, beat_in, beat_ok, ack_now, last_now, done_now, accept;
    logic         unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus.mem_addr[3:0];

    always_comb begin
        busy     = (state == CMD) || (state == DATA);
        accept   = (state == IDLE) && bus.mem_request;
        beat_in  = rwn_q ? bus.host_rxd_vld : bus.host_txd_ack;
        beat_ok  = busy && beat_in && !full;
        ack_now  = ack_seen || ((state == CMD) && bus.host_ack);
        // full marks "eighth beat already taken" while still waiting for host_ack
        last_now = full || (beat_ok && (beat == LAST_BEAT));
        done_now = busy && ack_now && last_now;

        err_set  = (bus.host_ack && (state != CMD))
                || ((bus.host_rxd_vld || bus.host_txd_ack) && !busy)
                || (busy && full && (bus.host_rxd_vld || bus.host_txd_ack))
                || (busy && rwn_q && bus.host_txd_ack)
                || (busy && !rwn_q && bus.host_rxd_vld);

        state_nx    = state;
        beat_nx     = beat;
        full_nx     = full;
        ack_seen_nx = ack_seen;

        case (state)
            IDLE: if (bus.mem_request) state_nx = CMD;
            CMD: begin
                if (done_now)          state_nx = DONE;
                else if (bus.host_ack) state_nx = DATA;
            end
            DATA: if (done_now) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (accept) begin
            beat_nx     = '0;
            full_nx     = 1'b0;
            ack_seen_nx = 1'b0;
        end
        if ((state == CMD) && bus.host_ack) ack_seen_nx = 1'b1;

        if (done_now) begin
            beat_nx = '0;
            full_nx = 1'b0;
        end else if (beat_ok) begin
            if (beat == LAST_BEAT) full_nx = 1'b1;
            else                   beat_nx = beat + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat     <= '0;
            full     <= 1'b0;
            ack_seen <= 1'b0;
            err_q    <= 1'b0;
            line_q   <= '0;
            rwn_q    <= 1'b0;
            wbuf     <= '0;
            rbuf     <= '0;
        end else begin
            state    <= state_nx;
            beat     <= beat_nx;
            full     <= full_nx;
            ack_seen <= ack_seen_nx;
            if (err_set) err_q <= 1'b1;
            if (accept) begin
                line_q <= bus.mem_addr[15:4];
                rwn_q  <= bus.mem_rwn;
                wbuf   <= bus.mem_write_data;
            end
            if (beat_ok && rwn_q) rbuf[{beat, 4'b0000} +: 16] <= bus.host_rxd;
        end
    end

    assign bus.host_req        = (state == CMD);
    assign bus.host_rwn        = rwn_q;
    assign bus.host_burst      = 1'b1;
    assign bus.host_addr       = BASE + {16'b0, line_q, 4'b0000};
    assign bus.host_txm        = 2'b00;
    assign bus.host_txd        = wbuf[{beat, 4'b0000} +: 16];
    assign bus.mem_finish      = (state == DONE);
    assign bus.mem_read_data   = rbuf;
    assign bus.mem_partial     = 1'b0;
    assign bus.mem_replace     = (state == DONE) && rwn_q;
    assign bus.mem_replace_set = line_q[4:0];
    assign bus.mem_replace_tag = line_q[11:5];
    assign bus.err             = err_q;
endmodule

// File: tb/tb_mp_line_bridge.sv
// Directed bench for mp_line_bridge: a transaction-level model is compared with the
// DUT every cycle, and literal expectations pin key results of each scenario.
module tb_mp_line_bridge;
    localparam logic [31:0] TB_BASE = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    mp_line_bridge_if bus();

    mp_line_bridge #(.BASE(TB_BASE), .BEATS(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 idle, 1 transfer open, 2 finishing.
    int          m_phase;
    bit          m_acked, m_rwn, m_err;
    int          m_n;
    logic [15:0] m_addr;
    logic [15:0] m_w [8];
    logic [15:0] m_r [8];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_acked = 0; m_rwn = 0; m_err = 0; m_n = 0; m_addr = '0;
            for (int k = 0; k < 8; k++) m_r[k] = '0;
        end else begin
            case (m_phase)
                0: begin
                    if (bus.host_ack || bus.host_rxd_vld || bus.host_txd_ack) m_err = 1;
                    if (bus.mem_request) begin
                        m_phase = 1; m_acked = 0; m_n = 0;
                        m_addr = bus.mem_addr; m_rwn = bus.mem_rwn;
                        for (int k = 0; k < 8; k++) m_w[k] = bus.mem_write_data[16*k +: 16];
                    end
                end
                1: begin
                    if (bus.host_ack) begin
                        if (m_acked) m_err = 1;
                        else m_acked = 1;
                    end
                    if (bus.host_rxd_vld) begin
                        if (!m_rwn || m_n == 8) m_err = 1;
                        else begin m_r[m_n] = bus.host_rxd; m_n++; end
                    end
                    if (bus.host_txd_ack) begin
                        if (m_rwn || m_n == 8) m_err = 1;
                        else m_n++;
                    end
                    if (m_acked && m_n == 8) m_phase = 2;
                end
                default: begin
                    if (bus.host_ack || bus.host_rxd_vld || bus.host_txd_ack) m_err = 1;
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            bit exp_req;
            exp_req = (m_phase == 1) && !m_acked;
            check("host_req", bus.host_req, exp_req);
            check("mem_finish", bus.mem_finish, m_phase == 2);
            check("err", bus.err, m_err);
            check("consts", {bus.mem_partial, bus.host_burst, bus.host_txm}, 4'b0100);
            if (exp_req) begin
                check("host_addr", bus.host_addr, TB_BASE + {16'b0, m_addr & 16'hFFF0});
                check("host_rwn", bus.host_rwn, m_rwn);
            end
            if (m_phase == 1 && !m_rwn && m_n < 8) check("host_txd", bus.host_txd, m_w[m_n]);
            if (m_phase == 2) begin
                check("mem_replace", bus.mem_replace, m_rwn);
                check("replace_set", bus.mem_replace_set, m_addr[8:4]);
                check("replace_tag", bus.mem_replace_tag, m_addr[15:9]);
                if (m_rwn)
                    check("mem_read_data", bus.mem_read_data,
                          {m_r[7], m_r[6], m_r[5], m_r[4], m_r[3], m_r[2], m_r[1], m_r[0]});
            end
        end
    end

    logic [15:0] txd_log [8];

    task automatic idle_host();
        bus.host_ack = 0; bus.host_txd_ack = 0; bus.host_rxd_vld = 0; bus.host_rxd = '0;
    endtask

    // i counts negedges from the first cycle host_req is visible.
    task automatic run_xfer(input bit rd, input logic [15:0] addr, input logic [127:0] line,
                            input int ack_at, input int beat_at, input int nbeats,
                            input int bad_at, output int fin_at);
        int nb;
        bit beat_now;
        nb = 0;
        fin_at = -1;
        @(negedge clk);
        bus.mem_request = 1; bus.mem_rwn = rd; bus.mem_addr = addr;
        bus.mem_write_data = rd ? ~line : line;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) check("req_latency", bus.host_req, 1'b1);
            if (i == 1) begin
                bus.mem_addr = ~addr; bus.mem_rwn = ~rd; bus.mem_write_data = ~bus.mem_write_data;
            end
            if (bus.mem_finish) begin
                fin_at = i;
                break;
            end
            bus.host_ack = (i == ack_at);
            beat_now = (i >= beat_at) && (nb < nbeats);
            if (rd) begin
                bus.host_rxd_vld = beat_now;
                bus.host_rxd     = (nb < 8) ? line[16*nb +: 16] : 16'hDEAD;
                bus.host_txd_ack = (i == bad_at);
            end else begin
                bus.host_txd_ack = beat_now;
                if (beat_now && nb < 8) txd_log[nb] = bus.host_txd;
                bus.host_rxd_vld = (i == bad_at);
            end
            if (beat_now) nb++;
        end
        idle_host();
        bus.mem_request = 0;
        if (fin_at < 0) check("finish_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] l1, w2, l3, l5, l6;
        int fin;
        l1 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        w2 = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
        l3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        l5 = 128'hA5A5_5A5A_0FF0_F00F_1234_5678_9ABC_DEF0;
        l6 = 128'hCAFE_BABE_0123_4567_89AB_CDEF_FEDC_BA98;

        bus.mem_request = 0; bus.mem_rwn = 0; bus.mem_addr = '0; bus.mem_write_data = '0;
        idle_host();
        repeat (3) @(negedge clk);
        check("rst_host_req", bus.host_req, 1'b0);
        check("rst_finish", bus.mem_finish, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_rdata", bus.mem_read_data, 128'h0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);

        // Read at 0x1234, ack 3 cycles after host_req, beats overlapping
        run_xfer(1, 16'h1234, l1, 3, 1, 8, -1, fin);
        check("t1_fin_cycle", fin, 9);
        check("t1_rdata", bus.mem_read_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        check("t1_set", bus.mem_replace_set, 5'h03);
        check("t1_tag", bus.mem_replace_tag, 7'h09);
        check("t1_replace", bus.mem_replace, 1'b1);
        check("t1_addr", bus.host_addr, 32'h0000_1230);
        check("t1_rwn", bus.host_rwn, 1'b1);

        // Write at 0xFFF0, txd_ack every cycle, issued back-to-back
        run_xfer(0, 16'hFFF0, w2, 2, 0, 8, -1, fin);
        check("t2_fin_cycle", fin, 8);
        check("t2_txd0", txd_log[0], 16'h0100);
        check("t2_txd1", txd_log[1], 16'h0302);
        check("t2_txd4", txd_log[4], 16'h0908);
        check("t2_txd7", txd_log[7], 16'h0F0E);
        check("t2_finish", bus.mem_finish, 1'b1);
        check("t2_replace", bus.mem_replace, 1'b0);
        check("t2_rwn", bus.host_rwn, 1'b0);
        check("t2_addr", bus.host_addr, 32'h0000_FFF0);

        // All read beats before host_ack
        run_xfer(1, 16'h0AB0, l3, 10, 0, 8, -1, fin);
        check("t3_fin_after_ack", fin, 11);
        check("t3_rdata", bus.mem_read_data, 128'h1111_2222_3333_4444_5555_6666_7777_8888);

        // Back-to-back read then write, ack coinciding with first beat
        run_xfer(1, 16'h5550, l5, 0, 0, 8, -1, fin);
        check("t4_read_fin", fin, 8);
        run_xfer(0, 16'h2220, w2, 1, 0, 8, -1, fin);
        check("t4_write_fin", fin, 8);
        check("t4_err", bus.err, 1'b0);

        // Reset in the middle of a write burst
        @(negedge clk);
        bus.mem_request = 1; bus.mem_rwn = 0; bus.mem_addr = 16'h7770; bus.mem_write_data = w2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) check("t5_beat4", bus.host_txd, 16'h0908);
            bus.host_ack = (i == 1);
            bus.host_txd_ack = 1;
        end
        #2 rst = 1;
        idle_host();
        #1;
        check("t5_req_async", bus.host_req, 1'b0);
        check("t5_no_finish", bus.mem_finish, 1'b0);
        @(negedge clk);
        bus.mem_request = 0;
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        check("t5_idle_finish", bus.mem_finish, 1'b0);
        run_xfer(1, 16'h4560, l5, 1, 2, 8, -1, fin);
        check("t5_read_fin", fin, 10);
        check("t5_rdata", bus.mem_read_data, 128'hA5A5_5A5A_0FF0_F00F_1234_5678_9ABC_DEF0);

        // Ninth rxd beat and txd_ack during a read
        run_xfer(1, 16'h0100, l6, 12, 0, 9, 10, fin);
        check("t6_fin", fin, 13);
        check("t6_err", bus.err, 1'b1);
        check("t6_rdata", bus.mem_read_data, 128'hCAFE_BABE_0123_4567_89AB_CDEF_FEDC_BA98);
        repeat (2) @(negedge clk);
        check("t6_err_sticky", bus.err, 1'b1);
        check("t6_rdata_hold", bus.mem_read_data, 128'hCAFE_BABE_0123_4567_89AB_CDEF_FEDC_BA98);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
